// File: rtl/pcm_recorder_pkg.sv
// Shared audio constants and recorder state encoding for the PCM record and playback paths.
package pcm_recorder_pkg;

  localparam int unsigned PCM_DEPTH  = 75611;
  localparam int unsigned PCM_ADDR_W = 17;
  localparam int unsigned PCM_DATA_W = 8;
  localparam int unsigned PROG_DIV   = 546;
  localparam int unsigned PROG_MAX   = 140;
  localparam int unsigned PROG_CNT_W = 10;
  localparam int unsigned PROG_W     = 8;

  typedef enum logic [1:0] {
    REC_IDLE = 2'd0,
    REC_ARM  = 2'd1,
    REC_REC  = 2'd2,
    REC_DONE = 2'd3
  } rec_state_e;

endpackage

// File: rtl/pcm_recorder_if.sv
// Recorder control, ADC sample input and BRAM write-port bundle.
interface pcm_recorder_if
  import pcm_recorder_pkg::*;
#(
  parameter int unsigned ADDR_W = PCM_ADDR_W,
  parameter int unsigned DATA_W = PCM_DATA_W
) ();

  logic              sample_tick;
  logic              rec_start;
  logic              rec_stop;
  logic [DATA_W-1:0] adc_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rec_len;
  logic              busy;
  logic              done;
  logic              full;
  logic [PROG_W-1:0] progress;

  modport slave (
    input  sample_tick, rec_start, rec_stop, adc_data,
    output wr_en, wr_addr, wr_data, rec_len, busy, done, full, progress
  );

  modport master (
    output sample_tick, rec_start, rec_stop, adc_data,
    input  wr_en, wr_addr, wr_data, rec_len, busy, done, full, progress
  );

endinterface

// File: rtl/pcm_recorder_progress_cnt.sv
// Divide-and-saturate progress bar counter: one step every DIV increments, capped at MAX.
module pcm_recorder_progress_cnt
  import pcm_recorder_pkg::*;
#(
  parameter int unsigned DIV   = PROG_DIV,
  parameter int unsigned MAX   = PROG_MAX,
  parameter int unsigned CNT_W = PROG_CNT_W,
  parameter int unsigned OUT_W = PROG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [OUT_W-1:0] progress
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX);

  logic [CNT_W-1:0] cnt;

  // clr wins over inc so a fresh recording always starts from zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      progress <= '0;
    end else if (clr) begin
      cnt      <= '0;
      progress <= '0;
    end else if (inc) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (progress < OUT_MAX) progress <= progress + OUT_W'(1);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pcm_recorder.sv
// Captures ADC samples on each sample tick into the PCM BRAM write port and tracks length/progress.
module pcm_recorder
  import pcm_recorder_pkg::*;
#(
  parameter int unsigned DEPTH    = PCM_DEPTH,
  parameter int unsigned ADDR_W   = PCM_ADDR_W,
  parameter int unsigned DATA_W   = PCM_DATA_W,
  parameter int unsigned PROG_DIV = pcm_recorder_pkg::PROG_DIV,
  parameter int unsigned PROG_MAX = pcm_recorder_pkg::PROG_MAX
) (
  input logic           clk,
  input logic           rst,
  pcm_recorder_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rec_state_e        state, state_n;
  logic              wr_c, arm_c, full_c;
  logic [ADDR_W-1:0] addr;
  logic              wr_en_q, busy_q, done_q, full_q;
  logic [ADDR_W-1:0] wr_addr_q, rec_len_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [PROG_W-1:0] progress_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= REC_IDLE;
    else      state <= state_n;
  end

  // Buffer-full takes priority over stop; a tick coinciding with stop is still written
  always_comb begin
    state_n = state;
    wr_c    = 1'b0;
    arm_c   = 1'b0;
    full_c  = 1'b0;
    case (state)
      REC_IDLE: begin
        if (bus.rec_start && !bus.rec_stop) begin
          state_n = REC_ARM;
          arm_c   = 1'b1;
        end
      end
      REC_ARM, REC_REC: begin
        wr_c = bus.sample_tick;
        if (bus.sample_tick && (addr == LAST_ADDR)) begin
          state_n = REC_DONE;
          full_c  = 1'b1;
        end else if (bus.rec_stop) begin
          state_n = REC_DONE;
        end else if (bus.sample_tick) begin
          state_n = REC_REC;
        end
      end
      REC_DONE: state_n = REC_IDLE;
      default:  state_n = REC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rec_len_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      wr_en_q <= wr_c;
      busy_q  <= (state_n == REC_ARM) || (state_n == REC_REC);
      done_q  <= (state_n == REC_DONE);
      if (arm_c) begin
        addr   <= '0;
        full_q <= 1'b0;
      end else if (wr_c) begin
        addr <= addr + ADDR_W'(1);
      end
      if (wr_c) begin
        wr_addr_q <= addr;
        wr_data_q <= bus.adc_data;
      end
      if (full_c) full_q <= 1'b1;
      // Length includes the sample written on the closing edge, if any
      if (state_n == REC_DONE) rec_len_q <= wr_c ? addr + ADDR_W'(1) : addr;
    end
  end

  pcm_recorder_progress_cnt #(
    .DIV   (PROG_DIV),
    .MAX   (PROG_MAX),
    .CNT_W (PROG_CNT_W),
    .OUT_W (PROG_W)
  ) u_progress (
    .clk      (clk),
    .rst      (rst),
    .clr      (arm_c),
    .inc      (wr_c),
    .progress (progress_q)
  );

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.rec_len  = rec_len_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.full     = full_q;
  assign bus.progress = progress_q;

endmodule

// File: doc/pcm_recorder.md
Name: pcm_recorder

Overview:
Write-side counterpart of the PCM playback ROM path. Captures 8-bit audio samples from the ADC front end once per sample tick and writes them sequentially into the PCM BRAM write port. Tracks the recorded length and drives the same 0..140 progress bar scale used by playback. Sits between the sample-rate tick generator and the BRAM, controlled by record/stop buttons that have already been debounced.

Parameters:
DEPTH, 75611, maximum number of samples; the BRAM size
ADDR_W, 17, address width; must satisfy 2^ADDR_W >= DEPTH
DATA_W, 8, sample width
PROG_DIV, 546, samples per progress step
PROG_MAX, 140, progress saturation value

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
sample_tick  in  1  one-clk-wide strobe at the sample rate
rec_start  in  1  one-clk pulse that starts a new recording
rec_stop  in  1  one-clk pulse that ends the recording
adc_data  in  DATA_W  current ADC sample; sampled on sample_tick
wr_en  out  1  BRAM write enable, one-clk pulse
wr_addr  out  ADDR_W  BRAM write address
wr_data  out  DATA_W  BRAM write data
rec_len  out  ADDR_W  number of samples in the last completed recording
busy  out  1  high in ARM and REC
done  out  1  one-clk pulse when a recording completes
full  out  1  last recording ended because the buffer filled
progress  out  8  progress bar position, 0..PROG_MAX

Behaviour:
- Reset (async, rst=0): state=IDLE. All outputs are 0, including rec_len and full. The internal address counter and progress counter are 0.
- State machine has four states:
  - IDLE: rec_start=1 and rec_stop=0 -> ARM. On entry to ARM, clear addr, progress, progress counter and full. If rec_start and rec_stop are both 1, stay in IDLE (stop dominates).
  - ARM: wait for the first sample_tick, then write the sample and go to REC. rec_stop -> DONE with rec_len=0.
  - REC: write one sample on each sample_tick. rec_stop -> DONE.
  - DONE: lasts one cycle. done=1 and rec_len is latched, then -> IDLE.
- Write on a tick in ARM or REC:
  - In the next clk: wr_en=1, wr_addr=addr, wr_data=adc_data as captured at the tick. Write latency is 1 clk.
  - addr increments after the write.
  - wr_en is 0 in all other cycles. wr_addr and wr_data hold their last values.
- Buffer full: the tick that writes addr=DEPTH-1 goes directly to DONE with full=1 and rec_len=DEPTH. Later ticks are ignored; there is no wrap-around.
- Tick and rec_stop in the same cycle: the sample is written first, then the block enters DONE. rec_len includes that sample.
- rec_start in ARM, REC or DONE is ignored. Restarting requires returning to IDLE.
- rec_len = number of samples written, in the range 0..DEPTH.
- Progress:
  - The progress counter (10 bits) increments on every write.
  - When the counter equals PROG_DIV-1 on a write, it clears and progress increments.
  - progress saturates at PROG_MAX.
  - progress holds its value through DONE and IDLE until the next ARM entry.
- busy=1 exactly in ARM and REC.
- Reset mid-recording: everything returns to reset values immediately. done is not pulsed, and rec_len=0.

Decomposition:
- The shared audio package holds: PCM_DEPTH (75611), PCM_ADDR_W (17), PCM_DATA_W (8), PROG_DIV (546), PROG_MAX (140), and the recorder state encoding localparams.
- pcm_rom takes the same constants from this package.
- One natural sub-module: pcm_progress_cnt, the divide-and-saturate progress counter with inc and clr inputs. It is shareable with the playback path.
- The FSM and address logic stay in pcm_recorder.

Test Plan:
1. DEPTH=8. Pulse rec_start, then send 3 ticks with adc_data=0x11, 0x22, 0x33, then rec_stop -> wr_en pulses at addresses 0, 1, 2 with data 11, 22, 33, each 1 clk after its tick. Then done=1 for 1 clk, rec_len=3, full=0, busy=0.
2. DEPTH=8. Pulse rec_start, then send 10 ticks -> exactly 8 writes at addresses 0..7. done asserts after the 8th write, with full=1 and rec_len=8. Ticks 9 and 10 produce no wr_en.
3. Tick and rec_stop in the same cycle during REC, after 4 samples -> a 5th write occurs at address 4, then done with rec_len=5.
4. rec_start and rec_stop together in IDLE -> stays IDLE with busy=0 and no done. rec_start during REC -> ignored, and addr continues without reset.
5. PROG_DIV=4, PROG_MAX=2. Record 13 samples -> progress steps to 1 after write 4 and to 2 after write 8, then stays at 2. It holds 2 after done and clears to 0 on the next rec_start.
6. Pull rst low mid-REC after 5 writes -> all outputs are 0 asynchronously with no done pulse. After release, a new rec_start writes from address 0.
